// File: rtl/thor2023_pma_region_table_pkg.sv
// Shared types and constants for the physical memory attribute (PMA) region table.
// Region descriptor layout, attribute entry layout, register field codes, lock codes,
// the register command bundle and the reset value of one table entry.
package thor2023_pma_region_table_pkg;

  localparam int MAX_ABITS = 48;

  // ASCII "LOCK" / "UNLK" as stored in the lock field
  localparam logic [31:0] LOCK_CODE = 32'h4C4F_434B;
  localparam logic [31:0] UNLK_CODE = 32'h554E_4C4B;

  typedef enum logic [1:0] {
    FLD_BASE  = 2'd0,
    FLD_LIMIT = 2'd1,
    FLD_AT    = 2'd2,
    FLD_LOCK  = 2'd3
  } field_e;

  // rwx[2] read, rwx[1] write, rwx[0] execute; dev_type 8'hFF marks the entry unusable
  typedef struct packed {
    logic [7:0] dev_type;
    logic [3:0] rwx;
  } pma_at_t;

  // at[n] is the attribute set used for privilege level n
  typedef struct packed {
    logic [MAX_ABITS-1:0] base;
    logic [MAX_ABITS-1:0] limit;
    pma_at_t [3:0]        at;
    logic [31:0]          lock;
  } region_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  padr;
    logic [127:0] data1;
  } wb_cmd_request128_t;

  function automatic logic [MAX_ABITS-1:0] addr_mask(input int abits);
    return {MAX_ABITS{1'b1}} >> (MAX_ABITS - abits);
  endfunction

  // The top region covers the whole space as a read/execute catch-all; the others start
  // empty and disabled.
  function automatic region_t reset_region(input bit last, input bit locked, input int abits);
    region_t r;
    r = '0;
    if (last) begin
      r.limit = addr_mask(abits);
      for (int j = 0; j < 4; j++) begin
        r.at[j].rwx      = 4'hD;
        r.at[j].dev_type = 8'h00;
      end
      r.lock = locked ? LOCK_CODE : UNLK_CODE;
    end else begin
      for (int j = 0; j < 4; j++) begin
        r.at[j].rwx      = 4'h0;
        r.at[j].dev_type = 8'hFF;
      end
      r.lock = UNLK_CODE;
    end
    return r;
  endfunction

endpackage

// File: rtl/thor2023_pma_region_table_match.sv
// Purpose: parallel address compare over all regions plus lowest-index priority encoder.
// Latency: combinational. Backpressure: none.
// Ports: tbl (region table), adr/pl (lookup address, privilege) -> sel (one-hot), num, hit.
module thor2023_pma_region_table_match
  import thor2023_pma_region_table_pkg::*;
#(
  parameter int NRGN  = 8,
  parameter int ABITS = 32
) (
  input  region_t [NRGN-1:0] tbl,
  input  logic [ABITS-1:0]   adr,
  input  logic [1:0]         pl,
  output logic [NRGN-1:0]    sel,
  output logic [3:0]         num,
  output logic               hit
);

  logic [NRGN-1:0] match;

  // base > limit can never satisfy both compares, so inverted regions drop out naturally
  always_comb begin
    match = '0;
    for (int i = 0; i < NRGN; i++) begin
      match[i] = (tbl[i].base[ABITS-1:0] <= adr) &&
                 (adr <= tbl[i].limit[ABITS-1:0]) &&
                 (tbl[i].at[pl].dev_type != 8'hFF);
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    sel = '0;
    num = '0;
    hit = 1'b0;
    for (int i = NRGN - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        num    = 4'(i);
        hit    = 1'b1;
      end
    end
  end

  // rwx and lock are not part of the compare
  logic unused_tbl;
  assign unused_tbl = ^tbl;

endmodule

// File: rtl/thor2023_pma_region_table.sv
// Purpose: flop-based PMA region table with register access and a lookup pipeline.
// Latency: register ack/dato 1 cycle; lookup results 2 cycles after lk_vld. Backpressure: none, one lookup per cycle.
// Ports: clk, rst (async active-low); cs_rgn/wbs_req -> ack/dato register port;
//        lk_vld/lk_adr/lk_acc/lk_pl -> rs_vld/region_num/region/sel/err/fault lookup port.
module thor2023_pma_region_table
  import thor2023_pma_region_table_pkg::*;
#(
  parameter int NRGN       = 8,
  parameter int ABITS      = 32,
  parameter bit RST_LOCKED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs_rgn,
  input  wb_cmd_request128_t wbs_req,
  output logic               ack,
  output logic [127:0]       dato,
  input  logic               lk_vld,
  input  logic [ABITS-1:0]   lk_adr,
  input  logic [1:0]         lk_acc,
  input  logic [1:0]         lk_pl,
  output logic               rs_vld,
  output logic [3:0]         region_num,
  output region_t            region,
  output logic [NRGN-1:0]    sel,
  output logic               err,
  output logic               fault
);

  localparam int RBITS = $clog2(NRGN);
  localparam logic [MAX_ABITS-1:0] AMASK = addr_mask(ABITS);

  region_t [NRGN-1:0] tbl;

  logic             reg_acc;
  logic             reg_wr;
  logic [RBITS-1:0] ridx;
  field_e           fld;
  logic [47:0]      field_val;

  assign reg_acc = cs_rgn & wbs_req.cyc & wbs_req.stb;
  assign reg_wr  = reg_acc & wbs_req.we;
  assign ridx    = wbs_req.padr[6 +: RBITS];
  assign fld     = field_e'(wbs_req.padr[5:4]);

  always_comb begin
    field_val = '0;
    case (fld)
      FLD_BASE:  field_val = tbl[ridx].base;
      FLD_LIMIT: field_val = tbl[ridx].limit;
      FLD_AT:    field_val = tbl[ridx].at;
      FLD_LOCK:  field_val = {16'h0, tbl[ridx].lock};
      default:   field_val = '0;
    endcase
  end

  // The lock word always accepts writes so a locked region can still be unlocked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NRGN; i++) begin
        tbl[i] <= reset_region(i == NRGN - 1, RST_LOCKED, ABITS);
      end
    end else if (reg_wr) begin
      if (fld == FLD_LOCK) begin
        tbl[ridx].lock <= wbs_req.data1[31:0];
      end else if (tbl[ridx].lock != LOCK_CODE) begin
        case (fld)
          FLD_BASE:  tbl[ridx].base  <= wbs_req.data1[47:0] & AMASK;
          FLD_LIMIT: tbl[ridx].limit <= wbs_req.data1[47:0] & AMASK;
          default:   tbl[ridx].at    <= wbs_req.data1[47:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack  <= 1'b0;
      dato <= '0;
    end else begin
      ack  <= reg_acc;
      dato <= (reg_acc && !wbs_req.we) ? {80'h0, field_val} : '0;
    end
  end

  logic unused_req;
  assign unused_req = ^{wbs_req.padr[31:6+RBITS], wbs_req.padr[3:0], wbs_req.data1[127:48]};

  // Stage 1: compare against the current table and snapshot the winning descriptor, so a
  // table write landing in the same edge cannot leak into this lookup's result.
  logic [NRGN-1:0] m_sel;
  logic [3:0]      m_num;
  logic            m_hit;

  thor2023_pma_region_table_match #(
    .NRGN  (NRGN),
    .ABITS (ABITS)
  ) u_match (
    .tbl (tbl),
    .adr (lk_adr),
    .pl  (lk_pl),
    .sel (m_sel),
    .num (m_num),
    .hit (m_hit)
  );

  logic            s1_vld;
  logic            s1_hit;
  logic [NRGN-1:0] s1_sel;
  logic [3:0]      s1_num;
  region_t         s1_region;
  logic [1:0]      s1_acc;
  logic [1:0]      s1_pl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld    <= 1'b0;
      s1_hit    <= 1'b0;
      s1_sel    <= '0;
      s1_num    <= '0;
      s1_region <= '0;
      s1_acc    <= '0;
      s1_pl     <= '0;
    end else begin
      s1_vld <= lk_vld;
      if (lk_vld) begin
        s1_hit    <= m_hit;
        s1_sel    <= m_sel;
        s1_num    <= m_num;
        s1_region <= m_hit ? tbl[m_num[RBITS-1:0]] : '0;
        s1_acc    <= lk_acc;
        s1_pl     <= lk_pl;
      end
    end
  end

  // Stage 2: permission check against the snapshot
  logic [2:0] s1_rwx;
  logic       denied;

  always_comb begin
    s1_rwx = s1_region.at[s1_pl].rwx[2:0];
    denied = 1'b1;
    case (s1_acc)
      2'd0:    denied = ~s1_rwx[2];
      2'd1:    denied = ~s1_rwx[1];
      2'd2:    denied = ~s1_rwx[0];
      default: denied = 1'b1;
    endcase
  end

  // region/region_num only move on a valid result; the flags are qualified by valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_vld     <= 1'b0;
      err        <= 1'b0;
      fault      <= 1'b0;
      sel        <= '0;
      region_num <= '0;
      region     <= '0;
    end else begin
      rs_vld <= s1_vld;
      err    <= s1_vld & ~s1_hit;
      fault  <= s1_vld & s1_hit & denied;
      sel    <= s1_vld ? s1_sel : '0;
      if (s1_vld) begin
        region_num <= s1_num;
        region     <= s1_region;
      end
    end
  end

endmodule

// File: tb/tb_thor2023_pma_region_table.sv
`timescale 1ns/1ps
module tb_thor2023_pma_region_table;
  import thor2023_pma_region_table_pkg::*;

  localparam int NRGN  = 8;
  localparam int ABITS = 32;
  localparam logic [31:0] LK = 32'h4C4F_434B;
  localparam logic [31:0] UL = 32'h554E_4C4B;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cs_rgn;
  wb_cmd_request128_t wbs_req;
  logic               ack;
  logic [127:0]       dato;
  logic               lk_vld;
  logic [ABITS-1:0]   lk_adr;
  logic [1:0]         lk_acc;
  logic [1:0]         lk_pl;
  logic               rs_vld;
  logic [3:0]         region_num;
  region_t            region;
  logic [NRGN-1:0]    sel;
  logic               err;
  logic               fault;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  thor2023_pma_region_table #(.NRGN(NRGN), .ABITS(ABITS), .RST_LOCKED(1'b1)) dut (
    .clk(clk), .rst(rst), .cs_rgn(cs_rgn), .wbs_req(wbs_req), .ack(ack), .dato(dato),
    .lk_vld(lk_vld), .lk_adr(lk_adr), .lk_acc(lk_acc), .lk_pl(lk_pl),
    .rs_vld(rs_vld), .region_num(region_num), .region(region), .sel(sel),
    .err(err), .fault(fault)
  );

  // ---------------- reference model: plain per-region arrays ----------------
  logic [31:0] m_base [NRGN];
  logic [31:0] m_limit[NRGN];
  logic [31:0] m_lock [NRGN];
  logic [3:0]  m_rwx  [NRGN][4];
  logic [7:0]  m_dev  [NRGN][4];

  typedef struct packed {
    logic            vld;
    logic            hit;
    logic [3:0]      num;
    logic [NRGN-1:0] sel;
    logic            fault;
    region_t         r;
  } exp_t;

  task automatic model_reset();
    for (int i = 0; i < NRGN; i++) begin
      m_base[i]  = 32'h0;
      m_limit[i] = (i == NRGN - 1) ? 32'hFFFF_FFFF : 32'h0;
      m_lock[i]  = (i == NRGN - 1) ? LK : UL;
      for (int j = 0; j < 4; j++) begin
        m_rwx[i][j] = (i == NRGN - 1) ? 4'hD : 4'h0;
        m_dev[i][j] = (i == NRGN - 1) ? 8'h00 : 8'hFF;
      end
    end
  endtask

  function automatic region_t model_region(input int i);
    region_t r;
    r = '0;
    r.base  = 48'(m_base[i]);
    r.limit = 48'(m_limit[i]);
    for (int j = 0; j < 4; j++) begin
      r.at[j].rwx      = m_rwx[i][j];
      r.at[j].dev_type = m_dev[i][j];
    end
    r.lock = m_lock[i];
    return r;
  endfunction

  function automatic logic [127:0] model_read(input int idx, input int fld);
    region_t r;
    r = model_region(idx);
    case (fld)
      0:       return 128'(m_base[idx]);
      1:       return 128'(m_limit[idx]);
      2:       return 128'(r.at);
      default: return 128'(m_lock[idx]);
    endcase
  endfunction

  task automatic model_write(input int idx, input int fld, input logic [127:0] d);
    if (fld == 3) m_lock[idx] = d[31:0];
    else if (m_lock[idx] != LK) begin
      if (fld == 0) m_base[idx] = d[31:0];
      else if (fld == 1) m_limit[idx] = d[31:0];
      else begin
        for (int j = 0; j < 4; j++) begin
          m_rwx[idx][j] = d[12*j +: 4];
          m_dev[idx][j] = d[12*j+4 +: 8];
        end
      end
    end
  endtask

  function automatic exp_t model_lookup(input logic vld, input logic [31:0] adr,
                                        input logic [1:0] acc, input logic [1:0] pl);
    exp_t e;
    e = '0;
    e.vld = vld;
    for (int i = 0; i < NRGN; i++) begin
      if (!e.hit && m_base[i] <= adr && adr <= m_limit[i] && m_dev[i][pl] != 8'hFF) begin
        int b;
        b = 2 - int'(acc);
        e.hit    = 1'b1;
        e.num    = 4'(i);
        e.sel[i] = 1'b1;
        e.r      = model_region(i);
        e.fault  = (acc == 2'd3) ? 1'b1 : ~m_rwx[i][pl][b];
      end
    end
    return e;
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input int idx, input int fld, input logic [127:0] d);
    cs_rgn        = 1'b1;
    wbs_req.cyc   = 1'b1;
    wbs_req.stb   = 1'b1;
    wbs_req.we    = we;
    wbs_req.padr  = (32'(idx) << 6) | (32'(fld) << 4);
    wbs_req.data1 = d;
  endtask

  task automatic clr_req();
    cs_rgn      = 1'b0;
    wbs_req.cyc = 1'b0;
    wbs_req.stb = 1'b0;
    wbs_req.we  = 1'b0;
  endtask

  task automatic reg_access(input logic we, input int idx, input int fld, input logic [127:0] d,
                            output logic a, output logic [127:0] q);
    set_req(we, idx, fld, d);
    if (we) model_write(idx, fld, d);
    tick();
    a = ack;
    q = dato;
    clr_req();
  endtask

  task automatic lookup(input logic [31:0] adr, input logic [1:0] acc, input logic [1:0] pl,
                        output exp_t e, output logic early);
    lk_vld = 1'b1; lk_adr = adr; lk_acc = acc; lk_pl = pl;
    e = model_lookup(1'b1, adr, acc, pl);
    tick();
    early = rs_vld;
    lk_vld = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic a;
    logic [127:0] q;
    clr_req();
    wbs_req.padr = '0; wbs_req.data1 = '0;
    lk_vld = 1'b0; lk_adr = '0; lk_acc = '0; lk_pl = '0;
    rst = 1'b0;
    model_reset();
    #12;
    tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL rst_ack got %0h want 0", ack); end
    tests_run++; if (dato !== 128'h0) begin tests_failed++; $display("FAIL rst_dato got %0h want 0", dato); end
    tests_run++; if ({rs_vld, err, fault} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags got %0b want 000", {rs_vld, err, fault}); end
    tests_run++; if (sel !== '0 || region_num !== 4'h0) begin tests_failed++; $display("FAIL rst_sel_num got %0h/%0h want 0/0", sel, region_num); end
    @(posedge clk); #1 rst = 1'b1;
    tick();
    foreach (m_base[i]) begin
      if (i == 0 || i == NRGN - 1) begin
        for (int f = 0; f < 4; f++) begin
          reg_access(1'b0, i, f, '0, a, q);
          tests_run++; if (a !== 1'b1 || q !== model_read(i, f)) begin tests_failed++; $display("FAIL rst_table r%0d f%0d got ack=%0b dat=%0h want ack=1 dat=%0h", i, f, a, q, model_read(i, f)); end
        end
      end
    end
  endtask

  task automatic test_default_lookup();
    exp_t e;
    logic early;
    for (int acc = 0; acc < 4; acc++) begin
      lookup(32'h1000, 2'(acc), 2'd0, e, early);
      tests_run++; if (early !== 1'b0 || rs_vld !== 1'b1) begin tests_failed++; $display("FAIL dflt_latency acc%0d got early=%0b vld=%0b want 0/1", acc, early, rs_vld); end
      tests_run++; if (region_num !== 4'd7 || sel !== 8'h80 || err !== 1'b0) begin tests_failed++; $display("FAIL dflt_hit acc%0d got num=%0d sel=%0h err=%0b want 7/80/0", acc, region_num, sel, err); end
      tests_run++; if (fault !== (acc == 1 || acc == 3) || fault !== e.fault) begin tests_failed++; $display("FAIL dflt_fault acc%0d got %0b want %0b", acc, fault, e.fault); end
      tests_run++; if (region !== e.r) begin tests_failed++; $display("FAIL dflt_region got %0h want %0h", region, e.r); end
    end
    tick();
    tests_run++; if ({rs_vld, err, fault, sel} !== '0) begin tests_failed++; $display("FAIL idle_flags got %0h want 0", {rs_vld, err, fault, sel}); end
    tests_run++; if (region_num !== 4'd7) begin tests_failed++; $display("FAIL idle_hold_num got %0d want 7", region_num); end
  endtask

  task automatic test_lock();
    logic a;
    logic [127:0] q;
    exp_t e;
    logic early;
    reg_access(1'b1, 7, 0, 128'h2000, a, q);
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL lock_wr_ack got %0b want 1", a); end
    tick();
    tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL lock_ack_single got %0b want 0", ack); end
    reg_access(1'b0, 7, 0, '0, a, q);
    tests_run++; if (q !== 128'h0 || q !== model_read(7, 0)) begin tests_failed++; $display("FAIL lock_blocked got %0h want 0", q); end
    reg_access(1'b1, 7, 3, 128'(UL), a, q);
    reg_access(1'b1, 7, 0, 128'h2000, a, q);
    reg_access(1'b0, 7, 0, '0, a, q);
    tests_run++; if (q !== 128'h2000) begin tests_failed++; $display("FAIL unlock_wr got %0h want 2000", q); end
    lookup(32'h1000, 2'd0, 2'd0, e, early);
    tests_run++; if (rs_vld !== 1'b1 || err !== 1'b1 || fault !== 1'b0 || sel !== '0 || region_num !== 4'd0) begin tests_failed++; $display("FAIL nomatch got vld=%0b err=%0b fault=%0b sel=%0h num=%0d want 1/1/0/0/0", rs_vld, err, fault, sel, region_num); end
    tests_run++; if (region !== '0 || e.hit !== 1'b0) begin tests_failed++; $display("FAIL nomatch_region got %0h want 0", region); end
  endtask

  task automatic test_priority();
    logic a;
    logic [127:0] q;
    exp_t e;
    logic early;
    reg_access(1'b1, 1, 0, 128'h0, a, q);
    reg_access(1'b1, 1, 1, 128'hFFFF, a, q);
    reg_access(1'b1, 1, 2, 128'h00F00F00F00F, a, q);
    reg_access(1'b1, 3, 0, 128'h8000, a, q);
    reg_access(1'b1, 3, 1, 128'h8FFF, a, q);
    reg_access(1'b1, 3, 2, 128'h00F00F00F00F, a, q);
    lookup(32'h8100, 2'd1, 2'd0, e, early);
    tests_run++; if (region_num !== 4'd1 || sel !== 8'h02 || err !== 1'b0 || fault !== 1'b0) begin tests_failed++; $display("FAIL priority got num=%0d sel=%0h err=%0b fault=%0b want 1/02/0/0", region_num, sel, err, fault); end
    tests_run++; if (region !== e.r) begin tests_failed++; $display("FAIL priority_region got %0h want %0h", region, e.r); end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    logic early;
    set_req(1'b1, 1, 1, 128'h80FF);
    lk_vld = 1'b1; lk_adr = 32'h8100; lk_acc = 2'd0; lk_pl = 2'd0;
    e = model_lookup(1'b1, 32'h8100, 2'd0, 2'd0);
    model_write(1, 1, 128'h80FF);
    tick();
    clr_req();
    lk_vld = 1'b0;
    tick();
    tests_run++; if (region_num !== 4'd1 || region_num !== e.num || region !== e.r) begin tests_failed++; $display("FAIL same_cycle_old got num=%0d lim=%0h want 1 lim=%0h", region_num, region.limit, e.r.limit); end
    lookup(32'h8100, 2'd0, 2'd0, e, early);
    tests_run++; if (region_num !== 4'd3 || sel !== 8'h08 || region !== e.r) begin tests_failed++; $display("FAIL same_cycle_new got num=%0d sel=%0h want 3/08", region_num, sel); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] want;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b0, 3, k, '0);
      want = model_read(3, k);
      tick();
      tests_run++; if (ack !== 1'b1 || dato !== want) begin tests_failed++; $display("FAIL b2b_read f%0d got ack=%0b dat=%0h want 1/%0h", k, ack, dato, want); end
    end
    clr_req();
    tick();
    tests_run++; if (ack !== 1'b0 || dato !== 128'h0) begin tests_failed++; $display("FAIL b2b_idle got ack=%0b dat=%0h want 0/0", ack, dato); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic exp_ack;
    logic [127:0] exp_dat;
    logic [127:0] d;
    int idx, fld;
    for (int c = 0; c <= 400; c++) begin
      lk_vld = (c < 400) && ($urandom_range(0, 9) < 7);
      lk_adr = 32'($urandom_range(0, 32'h1FFFF));
      lk_acc = 2'($urandom_range(0, 3));
      lk_pl  = 2'($urandom_range(0, 3));
      q.push_back(model_lookup(lk_vld, lk_adr, lk_acc, lk_pl));
      idx = $urandom_range(0, NRGN - 1);
      fld = $urandom_range(0, 3);
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      case (fld)
        0, 1: d[47:0] = 48'($urandom_range(0, 32'h1FFFF));
        2: for (int j = 0; j < 4; j++)
             d[12*j +: 12] = {($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom()), 4'($urandom())};
        default: d[31:0] = ($urandom_range(0, 9) < 3) ? LK : UL;
      endcase
      set_req(1'($urandom_range(0, 1)), idx, fld, d);
      cs_rgn      = (c < 400) && ($urandom_range(0, 9) < 4);
      wbs_req.stb = 1'($urandom_range(0, 3) != 0);
      exp_ack = cs_rgn & wbs_req.cyc & wbs_req.stb;
      exp_dat = (exp_ack && !wbs_req.we) ? model_read(idx, fld) : '0;
      if (exp_ack && wbs_req.we) model_write(idx, fld, d);
      tick();
      tests_run++; if (ack !== exp_ack || dato !== exp_dat) begin tests_failed++; $display("FAIL rand_reg c%0d got ack=%0b dat=%0h want %0b/%0h", c, ack, dato, exp_ack, exp_dat); end
      if (q.size() == 2) begin
        e = q.pop_front();
        tests_run++;
        if ({rs_vld, err, fault, sel} !== {e.vld, e.vld & ~e.hit, e.vld & e.fault, e.vld ? e.sel : '0} ||
            (e.vld && (region_num !== e.num || region !== e.r))) begin
          tests_failed++;
          $display("FAIL rand_lookup c%0d got vld=%0b err=%0b flt=%0b sel=%0h num=%0d want vld=%0b hit=%0b flt=%0b sel=%0h num=%0d",
                   c, rs_vld, err, fault, sel, region_num, e.vld, e.hit, e.fault, e.sel, e.num);
        end
      end
    end
    clr_req();
  endtask

  task automatic test_reset_midflight();
    logic a;
    logic [127:0] q;
    lk_vld = 1'b1; lk_adr = 32'h1000; lk_acc = 2'd0; lk_pl = 2'd0;
    set_req(1'b1, 0, 0, 128'h5555);
    tick();
    rst = 1'b0;
    lk_vld = 1'b0;
    clr_req();
    #2;
    tests_run++; if ({rs_vld, err, fault, sel, region_num, ack} !== '0 || dato !== '0 || region !== '0) begin tests_failed++; $display("FAIL midrst_outputs got vld=%0b err=%0b flt=%0b sel=%0h num=%0d ack=%0b", rs_vld, err, fault, sel, region_num, ack); end
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (rs_vld !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_vld k%0d got %0b want 0", k, rs_vld); end
    end
    reg_access(1'b0, 0, 0, '0, a, q);
    tests_run++; if (q !== 128'h0) begin tests_failed++; $display("FAIL midrst_table got %0h want 0", q); end
    reg_access(1'b0, NRGN - 1, 3, '0, a, q);
    tests_run++; if (q !== 128'(LK)) begin tests_failed++; $display("FAIL midrst_lock got %0h want %0h", q, LK); end
  endtask

  initial begin
    test_reset();
    test_default_lookup();
    test_lock();
    test_priority();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout after %0d tests", tests_run);
    $fatal(1, "timeout");
  end

endmodule
